// File: rtl/i2c_slave_port_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_port_pkg
//  Description : Shared definitions for the byte-level I2C slave engine:
//                FSM state encoding, register-decoder prefix constants and a
//                device-address compare helper.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_slave_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD       = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    // Payload width below the 2-bit A/D prefix of a write byte.
    localparam int         I2C_DATA_BITS = 6;
    // Prefixes the register decoder uses to tell address bytes from data bytes.
    localparam logic [1:0] A_ADDR        = 2'b10;
    localparam logic [1:0] D_ADDR        = 2'b01;

    // Bit 0 of both operands is the R/W flag / don't-care and is not compared.
    function automatic logic addr_match(input logic [7:0] rx_byte,
                                        input logic [7:0] dev_addr);
        return rx_byte[7:1] == dev_addr[7:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_line_filter
//  Description : Conditions one open-drain pad line: synchroniser chain,
//                counter-based glitch filter, and registered edge strobes.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk     in   system clock
//    rst_n   in   asynchronous active-low reset
//    i_pad   in   raw pad level
//    o_level out  filtered level (resets to 1)
//    o_rise  out  one-cycle strobe, asserted in the cycle o_level became 1
//    o_fall  out  one-cycle strobe, asserted in the cycle o_level became 0
// ============================================================================
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pad,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int              c_CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic w_sample;
    logic w_differs;
    logic w_accept;

    assign w_sample  = r_sync[SYNC_STAGES-1];
    assign w_differs = w_sample ^ r_level;
    // r_cnt holds how many consecutive differing samples preceded this one,
    // so the FILTER_LEN-th differing sample is the one that is accepted.
    assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync[0] <= i_pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            if (w_accept) begin
                r_level <= w_sample;
            end
            r_rise <= w_accept &  w_sample;
            r_fall <= w_accept & ~w_sample;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_port
//  Description : Byte-level I2C slave engine. Detects START/STOP, matches the
//                7-bit device address, strobes received write bytes out and
//                serialises read bytes from the register decoder. Owns the
//                ACK/NACK handshake on SDA.
//  Revision    : 1.0  initial release
//
//  Ports
//    CLK        in   system clock (20 MHz)
//    GSRn       in   asynchronous active-low reset
//    SCL_IN     in   pad SCL level
//    SDA_IN     in   pad SDA level
//    SDA_OE     out  1 = pull SDA low
//    RX_DATA    out  last received write byte, MSB first on the wire
//    RX_VALID   out  one-cycle strobe, RX_DATA valid
//    TX_REQ     out  one-cycle strobe, TX_DATA sampled this cycle
//    TX_DATA    in   read byte from the decoder
//    START_DET  out  one-cycle strobe on START / repeated START
//    STOP_DET   out  one-cycle strobe on STOP
//    BUSY       out  high from an addressed START until STOP
// ============================================================================
module i2c_slave_port
    import i2c_slave_port_pkg::*;
#(
    parameter logic [7:0] I2C_ADDR    = 8'h82,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       CLK,
    input  logic       GSRn,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       TX_REQ,
    input  logic [7:0] TX_DATA,
    output logic       START_DET,
    output logic       STOP_DET,
    output logic       BUSY
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
        .clk     (CLK),
        .rst_n   (GSRn),
        .i_pad   (SCL_IN),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
        .clk     (CLK),
        .rst_n   (GSRn),
        .i_pad   (SDA_IN),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    i2c_state_t r_state, w_state_nxt;

    logic [3:0] r_cnt,      w_cnt_nxt;      // rising edges seen in this byte, 0..8
    logic [6:0] r_shift,    w_shift_nxt;    // receive bits, last 7 seen
    logic [6:0] r_tx,       w_tx_nxt;       // read bits still to be driven
    logic       r_phase,    w_phase_nxt;    // ACK states: first falling edge done
    logic       r_rw,       w_rw_nxt;
    logic       r_sda_oe,   w_sda_oe_nxt;
    logic [7:0] r_rx_data,  w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_start,    w_start_nxt;
    logic       r_stop,     w_stop_nxt;
    logic       r_busy,     w_busy_nxt;
    logic       w_tx_req;

    logic       w_scl_prev;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_rx_byte;

    // SCL level before any edge reported this cycle, so an SDA edge that
    // coincides with an SCL edge is judged against the old SCL level.
    assign w_scl_prev = w_scl ^ (w_scl_rise | w_scl_fall);
    assign w_start    = w_sda_fall & w_scl_prev;
    assign w_stop     = w_sda_rise & w_scl_prev;
    assign w_rx_byte  = {r_shift, w_sda};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_phase_nxt    = r_phase;
        w_rw_nxt       = r_rw;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_start_nxt    = 1'b0;
        w_stop_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_tx_req       = 1'b0;

        if (w_start) begin
            w_state_nxt  = ST_ADDR;
            w_cnt_nxt    = 4'd0;
            w_phase_nxt  = 1'b0;
            w_sda_oe_nxt = 1'b0;
            w_start_nxt  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = 4'd0;
            w_phase_nxt  = 1'b0;
            w_sda_oe_nxt = 1'b0;
            w_stop_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte[6:0];
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt   = 4'd0;
                            w_phase_nxt = 1'b0;
                            w_rw_nxt    = w_rx_byte[0];
                            if (addr_match(w_rx_byte, I2C_ADDR)) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end

                ST_WR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte[6:0];
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt      = 4'd0;
                            w_phase_nxt    = 1'b0;
                            w_rx_data_nxt  = w_rx_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = ST_WR_ACK;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end

                ST_ADDR_ACK, ST_WR_ACK: begin
                    // First falling edge opens the ACK window, second closes it.
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_phase_nxt  = 1'b0;
                            w_cnt_nxt    = 4'd0;
                            w_sda_oe_nxt = 1'b0;
                            if ((r_state == ST_ADDR_ACK) && r_rw) begin
                                w_tx_req     = 1'b1;
                                w_tx_nxt     = TX_DATA[6:0];
                                w_sda_oe_nxt = ~TX_DATA[7];
                                w_state_nxt  = ST_RD;
                            end else begin
                                w_state_nxt  = ST_WR;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_cnt_nxt    = 4'd0;
                            w_phase_nxt  = 1'b0;
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = ST_RD_ACK;
                        end else begin
                            w_sda_oe_nxt = ~r_tx[6];
                            w_tx_nxt     = {r_tx[5:0], 1'b0};
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nxt = ST_IGNORE;
                        end else begin
                            w_phase_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_phase_nxt  = 1'b0;
                        w_cnt_nxt    = 4'd0;
                        w_tx_req     = 1'b1;
                        w_tx_nxt     = TX_DATA[6:0];
                        w_sda_oe_nxt = ~TX_DATA[7];
                        w_state_nxt  = ST_RD;
                    end
                end

                default: begin
                    // IDLE and IGNORE wait for the next START.
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge GSRn) begin
        if (!GSRn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge GSRn) begin
        if (!GSRn) begin
            r_cnt      <= 4'd0;
            r_shift    <= 7'd0;
            r_tx       <= 7'd0;
            r_phase    <= 1'b0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_phase    <= w_phase_nxt;
            r_rw       <= w_rw_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_start    <= w_start_nxt;
            r_stop     <= w_stop_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign SDA_OE    = r_sda_oe;
    assign RX_DATA   = r_rx_data;
    assign RX_VALID  = r_rx_valid;
    assign TX_REQ    = w_tx_req;
    assign START_DET = r_start;
    assign STOP_DET  = r_stop;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire
